// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default widths and the block splitter state encoding.
package rsa_pkg;

    localparam int DEF_MSG_W = 65;
    localparam int DEF_N_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } splitter_state_t;

endpackage

// File: rtl/rsa_block_splitter_if.sv
// Handshake bundles around the block splitter: plaintext word intake and block stream to the encryptor.
interface rsa_msg_if #(
    parameter int MSG_W = rsa_pkg::DEF_MSG_W,
    parameter int N_W   = rsa_pkg::DEF_N_W
);
    logic             msg_valid;
    logic             msg_ready;
    logic [MSG_W-1:0] msg_data;
    logic [N_W-1:0]   n;

    modport master (output msg_valid, output msg_data, output n, input msg_ready);
    modport slave  (input msg_valid, input msg_data, input n, output msg_ready);
endinterface

interface rsa_blk_if #(
    parameter int MSG_W = rsa_pkg::DEF_MSG_W,
    parameter int N_W   = rsa_pkg::DEF_N_W
);
    logic                     blk_valid;
    logic                     blk_ready;
    logic [N_W-1:0]           blk_data;
    logic [$clog2(MSG_W)-1:0] blk_idx;
    logic                     blk_last;

    modport master (output blk_valid, output blk_data, output blk_idx, output blk_last, input blk_ready);
    modport slave  (input blk_valid, input blk_data, input blk_idx, input blk_last, output blk_ready);
endinterface

// File: rtl/rsa_msb_index.sv
// Priority encoder: position of the most significant set bit of value, plus a flag for value == 0.
module rsa_msb_index #(
    parameter int W = 8
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] msb,
    output logic                 zero
);

    localparam int IDX_W = $clog2(W);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        msb  = {IDX_W{1'b0}};
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                msb  = IDX_W'(i);
                zero = 1'b0;
            end else begin
                msb  = msb;
                zero = zero;
            end
        end
    end

endmodule

// File: rtl/rsa_block_splitter.sv
// Slices a wide plaintext word LSB-first into k = floor(log2 n) bit blocks, each strictly below n,
// and streams them to the encryptor; degenerate moduli (n < 2) are dropped with an error pulse.
module rsa_block_splitter
    import rsa_pkg::*;
#(
    parameter int MSG_W = DEF_MSG_W,
    parameter int N_W   = DEF_N_W
) (
    input  logic         clk,
    input  logic         rst,
    rsa_msg_if.slave     msg,
    rsa_blk_if.master    blk,
    output logic         busy,
    output logic         err
);

    localparam int K_W   = $clog2(N_W);
    localparam int IDX_W = $clog2(MSG_W);
    localparam int REM_W = $clog2(MSG_W + 1);

    splitter_state_t  state_r, state_s;
    logic [MSG_W-1:0] shreg_r, shreg_s;
    logic [N_W-1:0]   n_r, n_s;
    logic [REM_W-1:0] rem_r, rem_s;
    logic [K_W-1:0]   k_r, k_s;
    logic             msg_ready_r, msg_ready_s;
    logic             blk_valid_r, blk_valid_s;
    logic [N_W-1:0]   blk_data_r, blk_data_s;
    logic [IDX_W-1:0] blk_idx_r, blk_idx_s;
    logic             blk_last_r, blk_last_s;
    logic             busy_r, busy_s;
    logic             err_r, err_s;

    logic [K_W-1:0]   msb_s;
    logic             n_zero_s;
    logic [MSG_W-1:0] shreg_next_s;
    logic [REM_W-1:0] rem_next_s;

    function automatic logic [REM_W-1:0] widen_k(input logic [K_W-1:0] k);
        return REM_W'(k);
    endfunction

    // Keeps only the k low bits; k <= N_W-1 so the block is always below any n with MSB at k.
    function automatic logic [N_W-1:0] low_bits(input logic [MSG_W-1:0] word, input logic [K_W-1:0] k);
        logic [N_W-1:0] mask;
        mask = (N_W'(1) << k) - N_W'(1);
        return word[N_W-1:0] & mask;
    endfunction

    rsa_msb_index #(.W(N_W)) u_msb_index (
        .value (n_r),
        .msb   (msb_s),
        .zero  (n_zero_s)
    );

    assign shreg_next_s = shreg_r >> k_r;
    assign rem_next_s   = rem_r - widen_k(k_r);

    // Next-state and next-output logic; registers hold unless a transition updates them.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        n_s         = n_r;
        rem_s       = rem_r;
        k_s         = k_r;
        msg_ready_s = 1'b0;
        blk_valid_s = blk_valid_r;
        blk_data_s  = blk_data_r;
        blk_idx_s   = blk_idx_r;
        blk_last_s  = blk_last_r;
        busy_s      = busy_r;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                msg_ready_s = 1'b1;
                if (msg.msg_valid && msg_ready_r) begin
                    shreg_s     = msg.msg_data;
                    n_s         = msg.n;
                    rem_s       = REM_W'(MSG_W);
                    busy_s      = 1'b1;
                    msg_ready_s = 1'b0;
                    state_s     = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (n_zero_s || (msb_s == {K_W{1'b0}})) begin
                    err_s       = 1'b1;
                    busy_s      = 1'b0;
                    msg_ready_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    k_s         = msb_s;
                    blk_idx_s   = {IDX_W{1'b0}};
                    blk_valid_s = 1'b1;
                    blk_data_s  = low_bits(shreg_r, msb_s);
                    blk_last_s  = (rem_r <= widen_k(msb_s));
                    state_s     = EMIT;
                end
            end
            EMIT: begin
                if (blk.blk_ready && blk_valid_r) begin
                    if (blk_last_r) begin
                        blk_valid_s = 1'b0;
                        blk_data_s  = {N_W{1'b0}};
                        blk_idx_s   = {IDX_W{1'b0}};
                        blk_last_s  = 1'b0;
                        busy_s      = 1'b0;
                        msg_ready_s = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        // Present the following block directly so the stream has no bubble.
                        shreg_s    = shreg_next_s;
                        rem_s      = rem_next_s;
                        blk_idx_s  = blk_idx_r + IDX_W'(1);
                        blk_data_s = low_bits(shreg_next_s, k_r);
                        blk_last_s = (rem_next_s <= widen_k(k_r));
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                blk_valid_s = 1'b0;
                busy_s      = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and registered-output storage; reset abandons any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shreg_r     <= {MSG_W{1'b0}};
            n_r         <= {N_W{1'b0}};
            rem_r       <= {REM_W{1'b0}};
            k_r         <= {K_W{1'b0}};
            msg_ready_r <= 1'b0;
            blk_valid_r <= 1'b0;
            blk_data_r  <= {N_W{1'b0}};
            blk_idx_r   <= {IDX_W{1'b0}};
            blk_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            n_r         <= n_s;
            rem_r       <= rem_s;
            k_r         <= k_s;
            msg_ready_r <= msg_ready_s;
            blk_valid_r <= blk_valid_s;
            blk_data_r  <= blk_data_s;
            blk_idx_r   <= blk_idx_s;
            blk_last_r  <= blk_last_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
        end
    end

    assign msg.msg_ready = msg_ready_r;
    assign blk.blk_valid = blk_valid_r;
    assign blk.blk_data  = blk_data_r;
    assign blk.blk_idx   = blk_idx_r;
    assign blk.blk_last  = blk_last_r;
    assign busy          = busy_r;
    assign err           = err_r;

endmodule

// File: tb/tb_rsa_block_splitter.sv
// Directed bench for rsa_block_splitter: block slicing for several moduli, error moduli,
// backpressure, back-to-back words and reset during emission.
module tb_rsa_block_splitter;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    int n_checks;
    int n_pass;

    logic [64:0] first_blk;
    logic [64:0] second_blk;
    logic [64:0] final_blk;

    rsa_msg_if #(.MSG_W(65), .N_W(8)) msg_bus ();
    rsa_blk_if #(.MSG_W(65), .N_W(8)) blk_bus ();

    rsa_block_splitter #(.MSG_W(65), .N_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .msg  (msg_bus),
        .blk  (blk_bus),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: stall three cycles on block 2
    task automatic run_word(input string tag, input logic [64:0] msg, input logic [7:0] nv,
                            input int k, input int nblk, input int mode,
                            input bit hold_next, input logic [64:0] next_msg);
        int waitc;
        int idx;
        int stall;
        int cyc;
        bit done;
        bit r;
        logic [64:0] rebuilt;
        logic [64:0] sh;
        logic [64:0] exp_blk;
        waitc = 0;
        while (!msg_bus.msg_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_eq({tag, "_ready_before"}, msg_bus.msg_ready, 1);
        msg_bus.msg_valid = 1'b1;
        msg_bus.msg_data  = msg;
        msg_bus.n         = nv;
        @(negedge clk);
        if (hold_next) msg_bus.msg_data = next_msg;
        else msg_bus.msg_valid = 1'b0;
        check_eq({tag, "_calc_busy"}, busy, 1);
        check_eq({tag, "_calc_ready"}, msg_bus.msg_ready, 0);
        check_eq({tag, "_calc_valid"}, blk_bus.blk_valid, 0);
        @(negedge clk);
        check_eq({tag, "_first_valid"}, blk_bus.blk_valid, 1);
        rebuilt = '0;
        idx = 0;
        stall = 0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 500) begin
            cyc++;
            sh = msg >> (idx * k);
            exp_blk = sh & ((65'd1 << k) - 65'd1);
            check_eq({tag, "_valid"}, blk_bus.blk_valid, 1);
            check_eq({tag, "_busy"}, busy, 1);
            check_eq({tag, "_msg_ready_low"}, msg_bus.msg_ready, 0);
            check_eq({tag, "_idx"}, blk_bus.blk_idx, idx);
            check_eq({tag, "_data"}, blk_bus.blk_data, exp_blk);
            check_eq({tag, "_last"}, blk_bus.blk_last, ((65 - idx * k) <= k) ? 1 : 0);
            check_eq({tag, "_below_n"}, (blk_bus.blk_data < nv) ? 1 : 0, 1);
            if (mode == 1) r = 1'($urandom_range(0, 1));
            else if (mode == 2 && idx == 2 && stall < 3) begin
                r = 1'b0;
                stall++;
            end else r = 1'b1;
            blk_bus.blk_ready = r;
            if (r) begin
                rebuilt = rebuilt | (65'(blk_bus.blk_data) << (idx * k));
                if (idx == 0) first_blk = 65'(blk_bus.blk_data);
                if (idx == 1) second_blk = 65'(blk_bus.blk_data);
                final_blk = 65'(blk_bus.blk_data);
                if (blk_bus.blk_last) done = 1'b1;
                idx++;
            end
            @(negedge clk);
        end
        blk_bus.blk_ready = 1'b0;
        check_eq({tag, "_completed"}, done, 1);
        check_eq({tag, "_block_count"}, idx, nblk);
        check_eq({tag, "_reassembled"}, rebuilt, msg);
        check_eq({tag, "_end_valid"}, blk_bus.blk_valid, 0);
        check_eq({tag, "_end_busy"}, busy, 0);
        check_eq({tag, "_end_ready"}, msg_bus.msg_ready, 1);
        if (mode == 2) check_eq({tag, "_stalled"}, stall, 3);
    endtask

    task automatic err_word(input string tag, input logic [7:0] nv);
        int waitc;
        waitc = 0;
        while (!msg_bus.msg_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_eq({tag, "_ready_before"}, msg_bus.msg_ready, 1);
        msg_bus.msg_valid = 1'b1;
        msg_bus.msg_data  = 65'h1_FFFF_0000_FFFF_0000;
        msg_bus.n         = nv;
        @(negedge clk);
        msg_bus.msg_valid = 1'b0;
        check_eq({tag, "_err_early"}, err, 0);
        check_eq({tag, "_calc_busy"}, busy, 1);
        check_eq({tag, "_calc_ready"}, msg_bus.msg_ready, 0);
        @(negedge clk);
        check_eq({tag, "_err_pulse"}, err, 1);
        check_eq({tag, "_err_busy"}, busy, 0);
        check_eq({tag, "_err_valid"}, blk_bus.blk_valid, 0);
        check_eq({tag, "_err_ready_back"}, msg_bus.msg_ready, 1);
        @(negedge clk);
        check_eq({tag, "_err_cleared"}, err, 0);
        check_eq({tag, "_err_no_blk"}, blk_bus.blk_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        n_checks = 0;
        n_pass   = 0;
        first_blk  = '0;
        second_blk = '0;
        final_blk  = '0;
        rst = 1'b0;
        msg_bus.msg_valid = 1'b0;
        msg_bus.msg_data  = '0;
        msg_bus.n         = '0;
        blk_bus.blk_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_eq("rst_msg_ready", msg_bus.msg_ready, 0);
        check_eq("rst_blk_valid", blk_bus.blk_valid, 0);
        check_eq("rst_blk_data", blk_bus.blk_data, 0);
        check_eq("rst_blk_idx", blk_bus.blk_idx, 0);
        check_eq("rst_blk_last", blk_bus.blk_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rel_ready_low", msg_bus.msg_ready, 0);
        @(negedge clk);
        check_eq("rel_ready_high", msg_bus.msg_ready, 1);

        // n = 21: k = 4, 17 blocks
        run_word("n21", 65'd81799572057445, 8'd21, 4, 17, 0, 1'b0, '0);
        check_eq("n21_blk0", first_blk, 65'h5);
        check_eq("n21_blk1", second_blk, 65'h6);
        check_eq("n21_blk16", final_blk, 65'h0);

        // n = 225: k = 7, 10 blocks, last block = msg[64:63] = 2'b11
        run_word("n225", 65'h1_DEAD_BEEF_CAFE_F00D, 8'd225, 7, 10, 0, 1'b0, '0);
        check_eq("n225_last2", final_blk, 65'h3);

        // n = 2: k = 1, one bit per block
        run_word("n2", 65'h1_0123_4567_89AB_CDEF, 8'd2, 1, 65, 0, 1'b0, '0);
        check_eq("n2_blk0", first_blk, 65'h1);
        check_eq("n2_blk64", final_blk, 65'h1);
        err_word("n1", 8'd1);
        err_word("n0", 8'd0);

        // backpressure
        run_word("stall", 65'd81799572057445, 8'd21, 4, 17, 2, 1'b0, '0);
        run_word("rand", 65'h1_DEAD_BEEF_CAFE_F00D, 8'd225, 7, 10, 1, 1'b0, '0);

        // back-to-back: second word offered while the first is still streaming
        run_word("b2b_a", 65'h0_1111_2222_3333_4444, 8'd225, 7, 10, 0, 1'b1, 65'h1_5555_6666_7777_8888);
        run_word("b2b_b", 65'h1_5555_6666_7777_8888, 8'd225, 7, 10, 0, 1'b0, '0);

        // reset while emitting block 5
        msg_bus.msg_valid = 1'b1;
        msg_bus.msg_data  = 65'd81799572057445;
        msg_bus.n         = 8'd21;
        @(negedge clk);
        msg_bus.msg_valid = 1'b0;
        blk_bus.blk_ready = 1'b1;
        cyc = 0;
        while (!(blk_bus.blk_valid && blk_bus.blk_idx == 7'd5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mid_idx5", blk_bus.blk_idx, 5);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", blk_bus.blk_valid, 0);
        check_eq("mid_rst_data", blk_bus.blk_data, 0);
        check_eq("mid_rst_idx", blk_bus.blk_idx, 0);
        check_eq("mid_rst_last", blk_bus.blk_last, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", msg_bus.msg_ready, 0);
        blk_bus.blk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("mid_rel_ready_low", msg_bus.msg_ready, 0);
        @(negedge clk);
        check_eq("mid_rel_ready_high", msg_bus.msg_ready, 1);
        check_eq("mid_rel_no_blk", blk_bus.blk_valid, 0);
        run_word("after_rst", 65'h1_0123_4567_89AB_CDEF, 8'd21, 4, 17, 0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
